// File: rtl/profile_ci_ctrl_pkg.sv
// Shared constants and types for the profiling custom-instruction front end:
// counter indices, control-word field offsets, readout select codes, done-FSM
// state encodings and the control-word decode helper.
package profile_ci_ctrl_pkg;

  localparam int unsigned NUM_CNT = 4;

  // Counter bank slots
  localparam int unsigned CNT_CPU   = 0;
  localparam int unsigned CNT_STALL = 1;
  localparam int unsigned CNT_IDLE  = 2;
  localparam int unsigned CNT_FREE  = 3;

  // Control word (ciValueB) field offsets, each field is NUM_CNT bits wide
  localparam int unsigned EN_LSB  = 0;
  localparam int unsigned DIS_LSB = 4;
  localparam int unsigned RST_LSB = 8;

  // Readout select code for the overflow flag word
  localparam logic [2:0] SEL_OVF = 3'd4;

  // Done FSM encodings, kept as plain constants for legacy tool flows
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Decoded control word
  typedef struct packed {
    logic [NUM_CNT-1:0] en;
    logic [NUM_CNT-1:0] dis;
    logic [NUM_CNT-1:0] clr;
  } ctrl_word_t;

  // Split the used 12 bits of the control word into per-counter fields
  function automatic ctrl_word_t decode_ctrl(input logic [11:0] b);
    ctrl_word_t c;
    c.en  = b[EN_LSB  +: NUM_CNT];
    c.dis = b[DIS_LSB +: NUM_CNT];
    c.clr = b[RST_LSB +: NUM_CNT];
    return c;
  endfunction

endpackage

// File: rtl/profile_ci_ctrl_if.sv
// Custom-instruction port between the CPU (master) and the profiling front
// end (slave). Signal names follow the OpenRISC custom-instruction port.
interface profile_ci_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             ciStart;
  logic             ciCke;
  logic [7:0]       ciN;
  logic [31:0]      ciValueA;
  logic [31:0]      ciValueB;
  logic             ciDone;
  logic [WIDTH-1:0] ciResult;

  // CPU side
  modport master (
    output ciStart,
    output ciCke,
    output ciN,
    output ciValueA,
    output ciValueB,
    input  ciDone,
    input  ciResult
  );

  // Profiling block side
  modport slave (
    input  ciStart,
    input  ciCke,
    input  ciN,
    input  ciValueA,
    input  ciValueB,
    output ciDone,
    output ciResult
  );

endinterface

// File: rtl/profile_event_counter.sv
// One WIDTH-bit event counter: async active-low reset, synchronous clear that
// wins over increment, and a wrap strobe for the cycle an increment rolls the
// count from all-ones back to zero.
module profile_event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear drops any event of the same cycle
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + One;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = inc_i & ~clr_i & (&count_q);

endmodule

// File: rtl/profile_ci_ctrl.sv
// Profiling custom-instruction front end. Decodes enable/disable/reset control
// words, gates four event counters and returns a selected count (or the
// overflow flag word) with a one-cycle ciDone pulse.
// Optional feature: define PROFILE_OVERFLOW_STICKY_EN to add per-counter
// sticky overflow flags readable at select code SEL_OVF.
module profile_ci_ctrl
  import profile_ci_ctrl_pkg::*;
#(
  parameter logic [7:0]  CUSTOM_ID = 8'd12,
  parameter int unsigned WIDTH     = 32
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    stall,
  input  logic                    busIdle,
  profile_ci_ctrl_if.slave        ci
);

  logic                accept;
  ctrl_word_t          ctrl;
  logic [NUM_CNT-1:0]  en_q, en_d;
  logic [NUM_CNT-1:0]  evt;
  logic [NUM_CNT-1:0]  clr;
  logic [NUM_CNT-1:0]  inc;
  logic [NUM_CNT-1:0]  wrap;
  logic [NUM_CNT-1:0]  ovf_rd;
  logic [WIDTH-1:0]    count [NUM_CNT];
  logic [WIDTH-1:0]    rdata;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [0:0]          state_q, state_d;

  // Only A[2:0] and B[11:0] carry meaning
  logic unused_bits;
  assign unused_bits = ^{ci.ciValueA[31:3], ci.ciValueB[31:12]};

  assign accept = ci.ciStart & ci.ciCke & (ci.ciN == CUSTOM_ID);
  assign ctrl   = decode_ctrl(ci.ciValueB[11:0]);

  // Per-counter events; CPU and free-running slots differ only in intent
  always_comb begin
    evt            = '0;
    evt[CNT_CPU]   = 1'b1;
    evt[CNT_STALL] = stall;
    evt[CNT_IDLE]  = busIdle;
    evt[CNT_FREE]  = 1'b1;
  end

  // Enable update (disable beats enable) and counter control strobes
  always_comb begin
    en_d = en_q;
    clr  = '0;
    if (accept) begin
      en_d = (en_q | ctrl.en) & ~ctrl.dis;
      clr  = ctrl.clr;
    end
    inc = en_q & evt;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    profile_event_counter #(
      .WIDTH (WIDTH)
    ) u_cnt (
      .clk_i   (clock),
      .rst_ni  (nReset),
      .clr_i   (clr[i]),
      .inc_i   (inc[i]),
      .count_o (count[i]),
      .wrap_o  (wrap[i])
    );
  end

`ifdef PROFILE_OVERFLOW_STICKY_EN
  logic [NUM_CNT-1:0] ovf_q, ovf_d;

  // Sticky flags: set on wrap, cleared only by the counter's reset bit
  always_comb begin
    ovf_d = (ovf_q & ~clr) | wrap;
  end

  // Overflow flag register
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_rd = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign ovf_rd      = '0;
`endif

  // Readout mux samples pre-update counts of the command cycle
  always_comb begin
    rdata = '0;
    case (ci.ciValueA[2:0])
      3'd0:    rdata = count[CNT_CPU];
      3'd1:    rdata = count[CNT_STALL];
      3'd2:    rdata = count[CNT_IDLE];
      3'd3:    rdata = count[CNT_FREE];
      SEL_OVF: rdata[NUM_CNT-1:0] = ovf_rd;
      default: rdata = '0;
    endcase
  end

  // Result is zero unless a command completes next cycle
  always_comb begin
    result_d = accept ? rdata : '0;
  end

  // Done FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: done FSM, enables, result register
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      en_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      result_q <= result_d;
    end
  end

  assign ci.ciDone   = (state_q == ST_DONE);
  assign ci.ciResult = result_q;

endmodule
